// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the fetch stage: NOP default, 2-bit predictor
// counter encodings and the saturating counter update.
package fetch_stage_pkg;

  localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0000;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  function automatic logic [1:0] ctr_update(input logic [1:0] ctr, input logic taken);
    if (taken) return (ctr == ST) ? ST : ctr + 2'd1;
    else return (ctr == SNT) ? SNT : ctr - 2'd1;
  endfunction

endpackage

// File: rtl/fetch_stage_branch_predictor.sv
// Direct-mapped BHT + BTB. The lookup reads flop contents combinationally,
// so a same-edge update is only visible to the next lookup.
module branch_predictor
  import fetch_stage_pkg::*;
#(
  parameter int PC_W    = 32,
  parameter int ENTRIES = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [PC_W-1:0] lookup_pc,
  output logic            pred_taken,
  output logic [PC_W-1:0] pred_target,
  input  logic            upd_valid,
  input  logic [PC_W-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic [PC_W-1:0] upd_target
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = PC_W - IDX_W;

  logic [1:0]       bht        [ENTRIES];
  logic [TAG_W-1:0] btb_tag    [ENTRIES];
  logic [PC_W-1:0]  btb_target [ENTRIES];
  logic [ENTRIES-1:0] btb_valid;

  logic [IDX_W-1:0] lookup_idx;
  logic [IDX_W-1:0] upd_idx;
  logic             hit;

  assign lookup_idx = lookup_pc[IDX_W-1:0];
  assign upd_idx    = upd_pc[IDX_W-1:0];

  assign hit         = btb_valid[lookup_idx] && (btb_tag[lookup_idx] == lookup_pc[PC_W-1:IDX_W]);
  assign pred_taken  = hit && bht[lookup_idx][1];
  assign pred_target = pred_taken ? btb_target[lookup_idx] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) bht[i] <= WNT;
      btb_valid <= '0;
    end else if (upd_valid) begin
      bht[upd_idx] <= ctr_update(bht[upd_idx], upd_taken);
      if (upd_taken) btb_valid[upd_idx] <= 1'b1;
    end
  end

  // Tag/target need no reset: they are qualified by btb_valid.
  always_ff @(posedge clk) begin
    if (upd_valid && upd_taken) begin
      btb_tag[upd_idx]    <= upd_pc[PC_W-1:IDX_W];
      btb_target[upd_idx] <= upd_target;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, next-PC selection and the IF/ID
// pipeline register, with branch prediction from branch_predictor.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int                PC_W       = 32,
  parameter int                INST_W     = 32,
  parameter int                BP_ENTRIES = 16,
  parameter logic [PC_W-1:0]   RESET_PC   = '0,
  parameter logic [INST_W-1:0] NOP_INST   = INST_W'(NOP_INST_DEFAULT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              PC_Write,
  input  logic              if_id_Write,
  input  logic              if_id_flush,
  input  logic              Wrong_prediction,
  input  logic [PC_W-1:0]   redirect_pc,
  input  logic              upd_valid,
  input  logic [PC_W-1:0]   upd_pc,
  input  logic              upd_taken,
  input  logic [PC_W-1:0]   upd_target,
  output logic [PC_W-1:0]   imem_addr,
  input  logic [INST_W-1:0] imem_data,
  output logic [INST_W-1:0] if_id_inst,
  output logic [PC_W-1:0]   if_id_pc,
  output logic              if_id_pred_taken,
  output logic [PC_W-1:0]   if_id_pred_target
);

  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] pc_next;
  logic            pred_taken;
  logic [PC_W-1:0] pred_target;

  branch_predictor #(
    .PC_W   (PC_W),
    .ENTRIES(BP_ENTRIES)
  ) u_bp (
    .clk        (clk),
    .rst        (rst),
    .lookup_pc  (pc),
    .pred_taken (pred_taken),
    .pred_target(pred_target),
    .upd_valid  (upd_valid),
    .upd_pc     (upd_pc),
    .upd_taken  (upd_taken),
    .upd_target (upd_target)
  );

  assign imem_addr = pc;

  // A redirect from EX overrides a stall: the wrong-path fetch is discarded anyway.
  always_comb begin
    pc_next = pc;
    if (Wrong_prediction) pc_next = redirect_pc;
    else if (!PC_Write)   pc_next = pc;
    else if (pred_taken)  pc_next = pred_target;
    else                  pc_next = pc + PC_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) pc <= RESET_PC;
    else     pc <= pc_next;
  end

  always_ff @(posedge clk) begin
    if (rst || Wrong_prediction || if_id_flush) begin
      if_id_inst        <= NOP_INST;
      if_id_pc          <= '0;
      if_id_pred_taken  <= 1'b0;
      if_id_pred_target <= '0;
    end else if (if_id_Write) begin
      if_id_inst        <= imem_data;
      if_id_pc          <= pc;
      if_id_pred_taken  <= pred_taken;
      if_id_pred_target <= pred_target;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Vector-table bench for fetch_stage: each record drives one cycle and
// holds the expected post-edge state, queued and checked after the edge.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] KEY = 32'hC0DE_0000;

  typedef struct {
    logic        rst, pcw, ifw, flush, wp;
    logic [31:0] redir;
    logic        uv, ut;
    logic [31:0] upc, utgt;
    logic [31:0] e_addr, e_pc;
    logic        e_nop, e_pt;
    logic [31:0] e_ptgt;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst, PC_Write, if_id_Write, if_id_flush, Wrong_prediction;
  logic [31:0] redirect_pc;
  logic        upd_valid, upd_taken;
  logic [31:0] upd_pc, upd_target;
  logic [31:0] imem_addr, imem_data;
  logic [31:0] if_id_inst, if_id_pc, if_id_pred_target;
  logic        if_id_pred_taken;

  int n_vec = 0;
  int n_err = 0;

  vec_t vecs[$];
  vec_t exp_q[$];

  always #5 clk = ~clk;

  // Instruction memory: each word is tagged with its own address.
  assign imem_data = KEY ^ imem_addr;

  fetch_stage #(.NOP_INST(NOP)) dut (
    .clk(clk), .rst(rst), .PC_Write(PC_Write), .if_id_Write(if_id_Write),
    .if_id_flush(if_id_flush), .Wrong_prediction(Wrong_prediction),
    .redirect_pc(redirect_pc), .upd_valid(upd_valid), .upd_pc(upd_pc),
    .upd_taken(upd_taken), .upd_target(upd_target), .imem_addr(imem_addr),
    .imem_data(imem_data), .if_id_inst(if_id_inst), .if_id_pc(if_id_pc),
    .if_id_pred_taken(if_id_pred_taken), .if_id_pred_target(if_id_pred_target)
  );

  task automatic check(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL v%0d %s: got %h want %h", idx, nm, act, exp);
    end
  endtask

  function automatic vec_t iv(logic [31:0] a, logic [31:0] p);
    vec_t v;
    v.rst = 0; v.pcw = 1; v.ifw = 1; v.flush = 0; v.wp = 0; v.redir = 0;
    v.uv = 0; v.ut = 0; v.upc = 0; v.utgt = 0;
    v.e_addr = a; v.e_pc = p; v.e_nop = 0; v.e_pt = 0; v.e_ptgt = 0;
    return v;
  endfunction

  function automatic vec_t nopv(logic [31:0] a);
    vec_t v = iv(a, 32'h0);
    v.e_nop = 1;
    return v;
  endfunction

  function automatic vec_t redir(logic [31:0] tgt);
    vec_t v = nopv(tgt);
    v.wp = 1; v.redir = tgt;
    return v;
  endfunction

  function automatic vec_t upd(vec_t base, logic [31:0] pc, logic taken, logic [31:0] tgt);
    vec_t v = base;
    v.uv = 1; v.upc = pc; v.ut = taken; v.utgt = tgt;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    rst = v.rst; PC_Write = v.pcw; if_id_Write = v.ifw; if_id_flush = v.flush;
    Wrong_prediction = v.wp; redirect_pc = v.redir;
    upd_valid = v.uv; upd_pc = v.upc; upd_taken = v.ut; upd_target = v.utgt;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v, e;

    // Free run from reset
    for (int i = 1; i <= 5; i++) vecs.push_back(iv(i, i - 1));
    // Full freeze at PC 5, then release
    for (int i = 0; i < 3; i++) begin
      v = iv(5, 4); v.pcw = 0; v.ifw = 0; vecs.push_back(v);
    end
    vecs.push_back(iv(6, 5));
    vecs.push_back(iv(7, 6));
    vecs.push_back(iv(8, 7));
    // Flush while PC held at 8
    v = nopv(8); v.pcw = 0; v.flush = 1; vecs.push_back(v);
    vecs.push_back(iv(9, 8));
    // Redirect overrides PC_Write=0
    v = redir(32'h40); v.pcw = 0; vecs.push_back(v);
    vecs.push_back(iv(32'h41, 32'h40));
    // PC held, IF/ID recaptures the same fetch
    v = iv(32'h41, 32'h41); v.pcw = 0; vecs.push_back(v);
    v = iv(32'h41, 32'h41); v.pcw = 0; vecs.push_back(v);
    vecs.push_back(iv(32'h42, 32'h41));
    // Train 0x12 taken -> 0x30
    vecs.push_back(upd(redir(32'h10), 32'h12, 1, 32'h30));
    vecs.push_back(iv(32'h11, 32'h10));
    vecs.push_back(iv(32'h12, 32'h11));
    v = iv(32'h30, 32'h12); v.e_pt = 1; v.e_ptgt = 32'h30; vecs.push_back(v);
    vecs.push_back(iv(32'h31, 32'h30));
    // Three not-taken (saturate at SNT), one taken -> WNT: falls through
    vecs.push_back(upd(iv(32'h32, 32'h31), 32'h12, 0, 0));
    vecs.push_back(upd(iv(32'h33, 32'h32), 32'h12, 0, 0));
    vecs.push_back(upd(iv(32'h34, 32'h33), 32'h12, 0, 0));
    vecs.push_back(upd(redir(32'h12), 32'h12, 1, 32'h30));
    vecs.push_back(iv(32'h13, 32'h12));
    vecs.push_back(iv(32'h14, 32'h13));
    // T,T -> ST with target 0x50; NT -> WT keeps the BTB entry
    vecs.push_back(upd(iv(32'h15, 32'h14), 32'h12, 1, 32'h50));
    vecs.push_back(upd(iv(32'h16, 32'h15), 32'h12, 1, 32'h50));
    vecs.push_back(upd(redir(32'h12), 32'h12, 0, 0));
    v = iv(32'h50, 32'h12); v.e_pt = 1; v.e_ptgt = 32'h50; vecs.push_back(v);
    vecs.push_back(iv(32'h51, 32'h50));
    // PC wrap
    vecs.push_back(redir(32'hFFFF_FFFF));
    vecs.push_back(iv(32'h0, 32'hFFFF_FFFF));
    vecs.push_back(iv(32'h1, 32'h0));
    vecs.push_back(iv(32'h2, 32'h1));
    // Same-cycle update and lookup at idx 2: lookup sees old (tag miss)
    vecs.push_back(upd(iv(32'h3, 32'h2), 32'h2, 1, 32'h60));
    vecs.push_back(redir(32'h2));
    v = iv(32'h60, 32'h2); v.e_pt = 1; v.e_ptgt = 32'h60; vecs.push_back(v);
    vecs.push_back(iv(32'h61, 32'h60));
    // Reset wins over redirect; predictor counters return to WNT
    v = redir(32'h0); v.redir = 32'h77; v.rst = 1; vecs.push_back(v);
    vecs.push_back(upd(iv(32'h1, 32'h0), 32'h2, 1, 32'h60));
    vecs.push_back(upd(iv(32'h2, 32'h1), 32'h2, 0, 0));
    vecs.push_back(iv(32'h3, 32'h2));

    // Reset sequence and reset-state check
    v = iv(0, 0); v.rst = 1; drive(v);
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    check("rst_addr", -1, imem_addr, 32'h0);
    check("rst_inst", -1, if_id_inst, NOP);
    check("rst_pc", -1, if_id_pc, 32'h0);
    check("rst_pt", -1, {31'b0, if_id_pred_taken}, 32'h0);
    check("rst_ptgt", -1, if_id_pred_target, 32'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      exp_q.push_back(vecs[i]);
      @(posedge clk);
      #1;
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL v%0d scoreboard: got empty queue want entry", i);
      end else begin
        e = exp_q.pop_front();
        check("imem_addr", i, imem_addr, e.e_addr);
        check("if_id_pc", i, if_id_pc, e.e_pc);
        check("if_id_inst", i, if_id_inst, e.e_nop ? NOP : (KEY ^ e.e_pc));
        check("pred_taken", i, {31'b0, if_id_pred_taken}, {31'b0, e.e_pt});
        check("pred_target", i, if_id_pred_target, e.e_ptgt);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage and IF/ID pipeline register for the pipelined CPU.
- Owns the PC and drives the instruction-memory address.
- Predicts branches with a direct-mapped BHT+BTB.
- Obeys the PC_Write / if_id_Write / if_id_flush controls from the stall detection unit.
- Accepts EX-stage redirects on Wrong_prediction, which also covers jr target resolution.

Parameters:
PC_W, 32, PC and target width (word-addressed; sequential PC = PC+1)
INST_W, 32, instruction width
BP_ENTRIES, 16, predictor entries, power of two; IDX_W = log2(BP_ENTRIES)
RESET_PC, 0, PC value after reset
NOP_INST, 0, encoding inserted into IF/ID on flush/reset

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
PC_Write  in  1  1 = PC may advance; 0 = hold PC
if_id_Write  in  1  1 = IF/ID captures new fetch; 0 = hold
if_id_flush  in  1  1 = load NOP_INST into IF/ID
Wrong_prediction  in  1  EX redirect request (mispredict or jr)
redirect_pc  in  PC_W  correct next PC, valid with Wrong_prediction
upd_valid  in  1  resolved conditional branch in EX, update predictor
upd_pc  in  PC_W  PC of the resolved branch
upd_taken  in  1  actual outcome
upd_target  in  PC_W  actual taken target
imem_addr  out  PC_W  = current PC (combinational from PC register)
imem_data  in  INST_W  instruction at imem_addr, same-cycle (asynchronous read)
if_id_inst  out  INST_W  IF/ID instruction
if_id_pc  out  PC_W  IF/ID PC
if_id_pred_taken  out  1  prediction made for if_id_inst
if_id_pred_target  out  PC_W  predicted target (0 if not taken)

Behaviour:
- Reset (rst=1 at edge):
  - PC <= RESET_PC; if_id_inst <= NOP_INST; if_id_pc, if_id_pred_taken, if_id_pred_target <= 0.
  - All BHT counters <= WNT (2'b01); all BTB valid bits <= 0.
  - Reset wins over every other input, including mid-redirect.
- Lookup (combinational, in IF):
  - idx = PC[IDX_W-1:0]; hit = btb_valid[idx] && btb_tag[idx] == PC[PC_W-1:IDX_W].
  - pred_taken = hit && bht[idx][1]; pred_target = btb_target[idx] when pred_taken, else 0.
- Next-PC priority:
  1. rst
  2. Wrong_prediction -> redirect_pc (regardless of PC_Write)
  3. !PC_Write -> hold
  4. pred_taken -> pred_target
  5. else PC+1, wrapping modulo 2^PC_W
- IF/ID update priority:
  1. rst
  2. Wrong_prediction or if_id_flush -> NOP_INST, pc 0, pred 0
  3. if_id_Write -> capture imem_data, PC, pred_taken, pred_target
  4. else hold
- Latency: an instruction fetched at cycle N appears on if_id_* at cycle N+1. A redirect applied at edge N is fetched in cycle N+1 and reaches IF/ID at N+2.
- Predictor update (at the edge, when upd_valid):
  - Counter at upd_pc index: increment if upd_taken, decrement otherwise; saturate at 0 and 3.
  - If upd_taken: write the BTB entry (valid=1, tag, upd_target) at that index.
  - Not-taken outcomes do not clear a BTB entry.
- Simultaneous lookup and update on the same index: the lookup sees pre-update contents (read-old). The update still lands.
- Stall interaction:
  - PC_Write=0 with if_id_Write=1 and if_id_flush=0: IF/ID re-captures the same PC/instruction. This is legal and the bench treats it as such.
  - PC_Write=0 with if_id_Write=0: full freeze, outputs stable.
- Predictor state is not changed by stalls or flushes.

Decomposition:
- Shared package/include: NOP_INST default, 2-bit counter encodings (SNT=00, WNT=01, WT=10, ST=11), and the saturating-update function.
- One sub-module, branch_predictor, holds the BHT+BTB arrays, the read-old lookup port and the update port.
- fetch_stage itself holds the PC register, the next-PC mux and the IF/ID register.

Test Plan:
1. Reset then free-run, all controls 1/0 idle, imem_data = PC-tagged pattern → if_id_pc sequence 0,1,2,3 one cycle behind imem_addr; if_id_pred_taken=0 throughout.
2. PC_Write=0, if_id_Write=0 for 3 cycles at PC=5 → imem_addr stays 5 and if_id_* is frozen. Release → next fetch is PC 6.
3. if_id_flush=1 for one cycle with PC_Write=0 at PC=8 → if_id_inst=NOP_INST, if_id_pc=0, imem_addr stays 8.
4. Wrong_prediction=1, redirect_pc=0x40, PC_Write=0 in the same cycle → next imem_addr=0x40 and IF/ID=NOP. One cycle later if_id_pc=0x40.
5. Predictor training:
   - upd_valid with upd_pc=0x12, taken, target=0x30 → counter goes WNT→WT.
   - On the next fetch of 0x12: pred_taken=1, next PC=0x30, if_id_pred_target=0x30.
   - Three not-taken updates → counter reaches SNT and 0x12 falls through to 0x13.
6. Same-cycle update and lookup at idx 2, plus wrap: PC=0xFFFFFFFF with no hit → next PC=0. Update at idx 2 in the same cycle as a fetch at idx 2 → that fetch uses the old prediction; the following fetch uses the new one.
